// File: rtl/core_io_pkg.sv
// Shared UART state encoding and frame constants for the core I/O unit.
package core_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with one-bit-extended pointers; full/empty come straight from pointer state.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps modulo 2*DEPTH by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/core_io_unit.sv
// Core-facing UART I/O unit: TX/RX FIFOs with 8N1 serial engines.
// Define CORE_IO_LOOPBACK_EN to feed the receiver from uart_txd instead of uart_rxd.
module core_io_unit
  import core_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_issued,
  input  logic [31:0] out_data,
  output logic        out_stall,
  input  logic        in_issued,
  output logic [31:0] in_data,
  output logic        in_stall,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  uart_state_e          tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop, tx_bit_end;

  uart_state_e          rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_head;
  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_bit_end;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                 rx_src, rx_in, rx_prev;
  logic                 unused_bits;

`ifdef CORE_IO_LOOPBACK_EN
  assign rx_src      = uart_txd;
  assign unused_bits = ^{out_data[31:DATA_BITS], uart_rxd};
`else
  assign rx_src      = uart_rxd;
  assign unused_bits = ^out_data[31:DATA_BITS];
`endif

  assign out_stall  = tx_full;
  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_in      = rx_sync[SYNC_STAGES-1];
  assign in_stall   = in_issued & rx_empty;
  assign rx_pop     = in_issued & ~rx_empty;
  assign in_data    = rx_empty ? 32'h0 : {{(32-DATA_BITS){1'b0}}, rx_head};

  io_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(out_issued), .push_data(out_data[DATA_BITS-1:0]),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  io_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // TX pops when a frame starts, either from idle or straight out of a stop bit.
  always_comb begin
    tx_pop = 1'b0;
    case (tx_state)
      IDLE:    tx_pop = ~tx_empty;
      STOP:    tx_pop = tx_bit_end & ~tx_empty;
      default: tx_pop = 1'b0;
    endcase
  end

  // TX serializer; uart_txd is a registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          tx_cnt <= '0;
          tx_idx <= '0;
          if (!tx_empty) begin
            tx_state <= START;
            tx_shift <= tx_head;
            uart_txd <= 1'b0;
          end
        end
        START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_state <= DATA;
            uart_txd <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
              tx_state <= STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              uart_txd <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            if (!tx_empty) begin
              tx_state <= START;
              tx_shift <= tx_head;
              uart_txd <= 1'b0;
            end else begin
              tx_state <= IDLE;
              uart_txd <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  // A good frame is pushed only on a high stop bit with room in the RX FIFO.
  always_comb begin
    if ((rx_state == STOP) && rx_bit_end && rx_in && !rx_full) begin
      rx_push = 1'b1;
    end else begin
      rx_push = 1'b0;
    end
  end

  // RX synchronizer, mid-bit sampler and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync      <= {SYNC_STAGES{1'b1}};
      rx_prev      <= 1'b1;
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_src};
      rx_prev <= rx_in;
      case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (rx_prev && !rx_in) rx_state <= START;
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_in ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == LAST_BIT) rx_state <= STOP;
            else rx_idx <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
            if (!rx_in) rx_frame_err <= 1'b1;
            else if (rx_full) rx_overrun <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_io_unit.sv
// Self-checking bench for core_io_unit: random bytes checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_core_io_unit;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_issued = 1'b0;
  logic [31:0] out_data = 32'h0;
  logic        in_issued = 1'b0;
  logic        drv_rxd = 1'b1;
  logic        loop_sel = 1'b0;
  logic        mon_en = 1'b1;
  logic        out_stall, in_stall, uart_txd, uart_rxd, rx_overrun, rx_frame_err;
  logic [31:0] in_data;

  int total = 0;
  int bad = 0;
  int stall_seen = 0;
  logic [7:0] tx_seen[$];
  time        tx_starts[$];

  assign uart_rxd = loop_sel ? uart_txd : drv_rxd;

  always #5 clk = ~clk;

  core_io_unit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
    .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Line decoder: turns the serial TX waveform back into bytes and frame start times.
  always begin
    @(negedge clk);
    if (mon_en && rst && uart_txd === 1'b0) begin
      logic [7:0] b;
      time t0;
      t0 = $time;
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = uart_txd;
      end
      repeat (CPB) @(negedge clk);
      if (uart_txd === 1'b1) begin
        tx_seen.push_back(b);
        tx_starts.push_back(t0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    out_issued = 1'b0;
    in_issued = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    int waitc = 0;
    out_issued = 1'b1;
    out_data = ($urandom() & 32'hFFFF_FF00) | {24'h0, b};
    while (out_stall && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    if (out_stall) check_eq("write_timeout", 64'd1, 64'd0);
    if (waitc > 0) stall_seen = 1;
    @(negedge clk);
    out_issued = 1'b0;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    int waitc = 0;
    in_issued = 1'b1;
    #1;
    while (in_stall && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    check_eq(tag, in_data, {24'h0, exp});
    @(negedge clk);
    in_issued = 1'b0;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    drv_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      drv_rxd = b[k];
      repeat (CPB) @(negedge clk);
    end
    drv_rxd = stop;
    repeat (CPB) @(negedge clk);
    drv_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    in_issued = 1'b1;
    #1;
    check_eq({tag, "_txd"}, uart_txd, 1'b1);
    check_eq({tag, "_out_stall"}, out_stall, 1'b0);
    check_eq({tag, "_in_data"}, in_data, 32'h0);
    check_eq({tag, "_in_stall"}, in_stall, 1'b1);
    check_eq({tag, "_overrun"}, rx_overrun, 1'b0);
    check_eq({tag, "_frame_err"}, rx_frame_err, 1'b0);
    in_issued = 1'b0;
  endtask

  initial begin
    logic [39:0] wave, expw;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic        lvl;
    int          n;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame waveform for 0xA5.
    write_byte(8'hA5);
    n = 0;
    while (uart_txd !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 40; i++) begin
      wave[i] = uart_txd;
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      b = 8'hA5;
      lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      for (int r = 0; r < CPB; r++) expw[j*CPB+r] = lvl;
    end
    check_eq("a5_wave", wave, expw);
    check_eq("a5_idle_after", uart_txd, 1'b1);
    repeat (5) @(negedge clk);

    // Back-to-back writes beyond FIFO capacity.
    tx_seen.delete();
    tx_starts.delete();
    exp_q.delete();
    stall_seen = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom());
      exp_q.push_back(b);
      write_byte(b);
    end
    check_eq("burst_stall_seen", stall_seen, 1);
    n = 0;
    while (tx_seen.size() < DEPTH + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("burst_count", tx_seen.size(), DEPTH + 2);
    for (int i = 0; i < DEPTH + 2 && i < tx_seen.size(); i++) begin
      check_eq($sformatf("burst_byte%0d", i), tx_seen[i], exp_q[i]);
      if (i > 0) check_eq($sformatf("burst_gap%0d", i), tx_starts[i] - tx_starts[i-1], 64'(FRAME * 10));
    end

    // Loopback of 0x3C through the external wire.
    loop_sel = 1'b1;
    repeat (4) @(negedge clk);
    write_byte(8'h3C);
    in_issued = 1'b1;
    #1;
    check_eq("lb_stall_early", in_stall, 1'b1);
    n = 0;
    while (in_stall && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("lb_latency_ok", (n >= 9 * CPB) && (n < 1000), 1'b1);
    check_eq("lb_data", in_data, 32'h0000_003C);
    @(negedge clk);
    #1;
    check_eq("lb_single_pop_stall", in_stall, 1'b1);
    check_eq("lb_single_pop_data", in_data, 32'h0);
    in_issued = 1'b0;

    // Random loopback bytes.
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom());
      exp_q.push_back(b);
      write_byte(b);
    end
    for (int i = 0; i < 3; i++) read_byte($sformatf("lb_rand%0d", i), exp_q[i]);
    check_eq("lb_no_overrun", rx_overrun, 1'b0);
    check_eq("lb_no_frame_err", rx_frame_err, 1'b0);
    loop_sel = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    // One-cycle glitch on the serial input.
    drv_rxd = 1'b0;
    @(negedge clk);
    drv_rxd = 1'b1;
    repeat (FRAME) @(negedge clk);
    check_idle_outputs("glitch");

    // Frame with a low stop bit.
    send_serial(8'($urandom()), 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_eq("ferr_flag", rx_frame_err, 1'b1);
    check_eq("ferr_no_overrun", rx_overrun, 1'b0);
    in_issued = 1'b1;
    #1;
    check_eq("ferr_fifo_empty", in_stall, 1'b1);
    in_issued = 1'b0;
    do_reset();
    check_eq("ferr_cleared", rx_frame_err, 1'b0);

    // Overrun: one frame more than the RX FIFO holds.
    exp_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom());
      exp_q.push_back(b);
      send_serial(b, 1'b1);
    end
    check_eq("ovr_flag", rx_overrun, 1'b1);
    check_eq("ovr_no_frame_err", rx_frame_err, 1'b0);
    for (int i = 0; i < DEPTH; i++) read_byte($sformatf("ovr_byte%0d", i), exp_q[i]);
    in_issued = 1'b1;
    #1;
    check_eq("ovr_drained", in_stall, 1'b1);
    in_issued = 1'b0;

    // Reset in the middle of a TX frame.
    write_byte(8'($urandom()));
    write_byte(8'($urandom()));
    n = 0;
    while (uart_txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * CPB) @(negedge clk);
    #2 rst = 1'b0;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    lvl = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      lvl = lvl & uart_txd;
    end
    check_eq("midreset_line_stays_high", lvl, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_io_unit.md
CORE_IO_UNIT -- requirements
Module: core_io_unit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (minimum 4).
REQ-002 Parameter FIFO_DEPTH, default 16, entries per direction FIFO (power of 2, minimum 2).
REQ-003 clk  input  1  core clock; all state on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 out_issued  input  1  core requests a byte transmit this cycle.
REQ-006 out_data  input  32  transmit payload; only bits [7:0] are sent.
REQ-007 out_stall  output  1  TX FIFO full; core holds out_issued and out_data.
REQ-008 in_issued  input  1  core requests a received byte this cycle.
REQ-009 in_data  output  32  RX FIFO head, zero-extended to 32 bits.
REQ-010 in_stall  output  1  read cannot complete this cycle.
REQ-011 uart_rxd  input  1  asynchronous serial input.
REQ-012 uart_txd  output  1  serial output.
REQ-013 rx_overrun  output  1  sticky flag: a byte was dropped because the RX FIFO was full.
REQ-014 rx_frame_err  output  1  sticky flag: a byte was dropped because its stop bit was 0.

Function
REQ-015 Push to TX FIFO: out_issued & !out_stall; out_stall is the registered TX-full flag only.
REQ-016 A simultaneous TX pop while full leaves out_stall=1 in that cycle; the push is accepted in the next cycle.
REQ-017 in_stall = in_issued & rx_empty, combinational; an RX pop occurs on in_issued & !in_stall.
REQ-018 in_data shows the RX head whenever the FIFO is non-empty, else 0.
REQ-019 TX FSM states: IDLE, START, DATA, STOP; each bit lasts exactly CLKS_PER_BIT cycles; frame is 8N1, LSB first.
REQ-020 TX moves IDLE->START in the cycle after the FIFO becomes non-empty and pops the byte on that transition.
REQ-021 After STOP, TX returns to IDLE; if the FIFO is non-empty it starts the next frame immediately, with no extra idle bit.
REQ-022 uart_rxd passes through a 2-flop synchronizer before the RX FSM.
REQ-023 RX FSM states: IDLE, START, DATA, STOP; a falling edge in IDLE enters START.
REQ-024 In START, the line is sampled at CLKS_PER_BIT/2; if it is high, the start is false and RX returns to IDLE.
REQ-025 Data bits and the stop bit are sampled at mid-bit, every CLKS_PER_BIT cycles.
REQ-026 Stop bit = 1 and FIFO not full: the byte is pushed.
REQ-027 Stop bit = 0: the byte is dropped and rx_frame_err is set.
REQ-028 Stop bit = 1 and FIFO full: the byte is dropped and rx_overrun is set.
REQ-029 A push into the RX FIFO while the core pops in the same cycle is accepted when not full.
REQ-030 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty are derived from the MSB and the remaining bits.

Reset
REQ-031 While rst=0: uart_txd=1, both FSMs are IDLE, FIFOs are empty, out_stall=0, in_data=0, and both sticky flags are 0.
REQ-032 Reset mid-frame aborts the frame; the TX line returns to 1 asynchronously.

Configuration
REQ-033 Macro CORE_IO_LOOPBACK_EN: when defined, the RX synchronizer input is uart_txd internally and uart_rxd is ignored.
REQ-034 When CORE_IO_LOOPBACK_EN is undefined, the RX synchronizer input is uart_rxd.

Structure
REQ-035 Package core_io_pkg holds the UART FSM state enum and the constants DATA_BITS=8 and SYNC_STAGES=2.
REQ-036 Sub-module io_fifo (parameters WIDTH, DEPTH) is instantiated once for TX and once for RX.

Verification
REQ-037 CLKS_PER_BIT=4, write 0x000000A5 -> uart_txd shows 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles.
REQ-038 Issue FIFO_DEPTH+2 back-to-back writes -> out_stall rises once the FIFO is full, all bytes arrive in order, and there are no gaps between frames.
REQ-039 With loopback, send 0x3C, then in_issued -> in_stall=1 until reception completes, then in_data=0x0000003C for one pop.
REQ-040 Drive a 1-cycle low glitch on uart_rxd -> no push and no flags set.
REQ-041 Drive a frame with stop=0 -> rx_frame_err=1 and the FIFO stays empty.
REQ-042 Send FIFO_DEPTH+1 frames without reading -> rx_overrun=1 and the first FIFO_DEPTH bytes are intact; assert rst mid-frame -> all outputs return to their reset values.
